// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] SUB3_THRESH   = 4'd8;

  // Smallest width w with 2^w > 10^ndig - 1, i.e. 2^w >= 10^ndig.
  function automatic int min_bin_w(input int ndig);
    int p;
    p = 1;
    for (int i = 0; i < ndig; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_sub3.sv
// Reverse double-dabble digit cell: a nibble of 8 or more is corrected by -3.
module sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  output logic [BCD_DIGIT_W-1:0] y
);

  assign y = (a >= SUB3_THRESH) ? (a - 4'd3) : a;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, result valid BIN_W+1 cycles after accept; holds result until out_ready.
// BCD2BIN_DIGIT_CHECK_EN: reject digits > 9 at accept, reporting err with a zero result one cycle later.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIN_W-1:0]          bin_out,
  output logic                      err
);

  localparam int BCD_W = BCD_DIGIT_W * NDIG;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (BIN_W < min_bin_w(NDIG)) begin : g_bin_w_check
    $error("bcd_to_bin_seq: BIN_W too small for NDIG digits");
  end

  state_t               state_q, state_d;
  logic [BCD_W-1:0]     dig_q, dig_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       dig_sub3;

  // One step: shift the joint register right, then correct every digit.
  assign shifted = {dig_q, bin_q} >> 1;

  for (genvar g = 0; g < NDIG; g++) begin : g_sub3
    sub3 u_sub3 (
      .a (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .y (dig_sub3[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic any_bad;
  logic err_q, err_d;

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        any_bad = 1'b1;
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && in_valid) begin
      err_d = any_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dig_d   = bcd_in;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          if (any_bad) begin
            dig_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CONV: begin
        dig_d = dig_sub3;
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dig_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin_out   = bin_q;

endmodule
